// File: rtl/md_unit_if.sv
// Issue/result bundle between the hazard/EX control and the multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, output op, output a, output b,
                    input busy, input hi, input lo);
    modport slave  (input start, input op, input a, input b,
                    output busy, output hi, output lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO; results are computed from latched
// operands and committed after a fixed busy interval.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    md_unit_if.slave  bus
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;

    // op_q[1] selects divide, op_q[0] selects unsigned.
    logic        is_div, is_signed, a_neg, b_neg, div_by_zero;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] mag_a, mag_b, div_b, uq, ur, quo, rem;

    always_comb begin
        is_div      = op_q[1];
        is_signed   = ~op_q[0];
        mul_a       = {{32{is_signed & a_q[31]}}, a_q};
        mul_b       = {{32{is_signed & b_q[31]}}, b_q};
        prod        = mul_a * mul_b;
        a_neg       = is_signed & a_q[31];
        b_neg       = is_signed & b_q[31];
        mag_a       = a_neg ? (32'd0 - a_q) : a_q;
        mag_b       = b_neg ? (32'd0 - b_q) : b_q;
        div_by_zero = (b_q == 32'd0);
        div_b       = div_by_zero ? 32'd1 : mag_b;
        uq          = mag_a / div_b;
        ur          = mag_a % div_b;
        // Negating 0x80000000 wraps back onto itself, which is the required overflow result.
        quo         = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem         = a_neg ? (32'd0 - ur) : ur;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.op)
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            a_d     = bus.a;
                            b_d     = bus.b;
                            op_d    = bus.op[1:0];
                            cnt_d   = bus.op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                            state_d = StRun;
                        end
                        OpMthi:  hi_d = bus.a;
                        OpMtlo:  lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (!is_div) begin
                        {hi_d, lo_d} = prod;
                    end else if (!div_by_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, hand-written timing sequences and random ops
// checked against an arithmetic reference model.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cycles_for(input logic [2:0] op);
        if (op <= 3'd1) return MC;
        if (op <= 3'd3) return DC;
        return 0;
    endfunction

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
    function automatic void model_step(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        longint      sq, sr;
        logic [63:0] p, tmp;
        case (op)
            3'd0: begin
                sq = longint'($signed(a)) * longint'($signed(b));
                tmp = sq;
                {m_hi, m_lo} = tmp;
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = p;
            end
            3'd2: if (b != 0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                tmp = sq; m_lo = tmp[31:0];
                tmp = sr; m_hi = tmp[31:0];
            end
            3'd3: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endfunction

    // Drives one start pulse; returns just after the sampling edge E0 with operands scrambled.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic exec(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
        int cyc;
        issue(op, a, b);
        check32({name, ".busy_e0"}, {31'd0, bus.busy}, {31'd0, exp_cyc > 0});
        wait_done(cyc);
        check_int({name, ".cycles"}, cyc, exp_cyc);
        check32({name, ".hi"}, bus.hi, exp_hi);
        check32({name, ".lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        vec_t vecs[$];
        int   cyc;
        logic [2:0]  op;
        logic [31:0] a, b;

        vecs.push_back('{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC});
        vecs.push_back('{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MC});
        vecs.push_back('{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC});
        vecs.push_back('{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        DC});
        vecs.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC});
        vecs.push_back('{3'd4, 32'h11,       32'd0,        32'h11,       32'h80000000, 0});
        vecs.push_back('{3'd5, 32'h22,       32'd0,        32'h11,       32'h22,       0});
        vecs.push_back('{3'd3, 32'd12345,    32'd0,        32'h11,       32'h22,       DC});
        vecs.push_back('{3'd2, 32'hFFFF0000, 32'd0,        32'h11,       32'h22,       DC});
        vecs.push_back('{3'd4, 32'hDEADBEEF, 32'd5,        32'hDEADBEEF, 32'h22,       0});
        vecs.push_back('{3'd6, 32'h12345678, 32'd9,        32'hDEADBEEF, 32'h22,       0});
        vecs.push_back('{3'd7, 32'h87654321, 32'd9,        32'hDEADBEEF, 32'h22,       0});

        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check32("reset.busy", {31'd0, bus.busy}, 32'd0);
        check32("reset.hi", bus.hi, 32'd0);
        check32("reset.lo", bus.lo, 32'd0);

        foreach (vecs[i]) begin
            exec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_cyc,
                 vecs[i].exp_hi, vecs[i].exp_lo);
        end
        m_hi = 32'hDEADBEEF;
        m_lo = 32'h22;

        // Reset asserted for the fourth edge of a DIV discards it and clears HI/LO.
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check32("rst_mid.busy", {31'd0, bus.busy}, 32'd0);
        check32("rst_mid.hi", bus.hi, 32'd0);
        check32("rst_mid.lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0;
        m_lo = 0;
        model_step(3'd3, 32'd100, 32'd7);
        exec("after_rst", 3'd3, 32'd100, 32'd7, DC, m_hi, m_lo);

        // MTLO/MTHI during RUN must be ignored.
        issue(3'd0, 32'd7, 32'd9);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.a     = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus.op    = 3'd4;
        bus.a     = 32'h66;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc);
        check_int("mt_in_run.cycles", cyc + 2, MC);
        check32("mt_in_run.hi", bus.hi, 32'd0);
        check32("mt_in_run.lo", bus.lo, 32'd63);

        // Start held high: one op from E0 operands, E_N restart ignored, E_N+1 accepted.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(posedge clk);
        #1;
        bus.a = 32'd5;
        bus.b = 32'd6;
        wait_done(cyc);
        check_int("held.cycles", cyc, MC);
        check32("held.lo1", bus.lo, 32'd12);
        check32("held.hi1", bus.hi, 32'd0);
        @(posedge clk);
        #1;
        check32("held.busy_restart", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        wait_done(cyc);
        check_int("held.cycles2", cyc, MC);
        check32("held.lo2", bus.lo, 32'd30);
        m_hi = 32'd0;
        m_lo = 32'd30;

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                default: b = $urandom;
            endcase
            model_step(op, a, b);
            exec($sformatf("rand%0d", i), op, a, b, cycles_for(op), m_hi, m_lo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
